// File: rtl/maze_game_controller_if.sv
// Maze loader handshake between the game sequencer and the maze store.
//   maze_load  : sequencer requests a load of maze `level`
//   level      : index of the maze to load (also the current game level)
//   maze_ready : loader reports the requested maze is in place
// master = sequencer side, slave = maze loader side.
interface maze_game_controller_if #(
   parameter int LVL_W = 2
);
   logic             maze_load;
   logic [LVL_W-1:0] level;
   logic             maze_ready;

   modport master (
      output maze_load,
      output level,
      input  maze_ready
   );

   modport slave (
      input  maze_load,
      input  level,
      output maze_ready
   );
endinterface

// File: rtl/maze_game_controller.sv
// Top-level game sequencer: steps through levels, requests maze loads,
// gates player movement, counts moves and runs the per-level countdown.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           level-sampled start/continue request
//   move            one-cycle move-attempt pulse
//   win             player is on the maze end cell
//   game_rst        one-cycle player-reset pulse (clears move count)
//   maze_bus        loader handshake (maze_load, level, maze_ready)
//   player_en       player movement enable
//   move_count      moves made this level (saturating)
//   time_left       seconds left in this level
//   state           FSM state encoding
//   game_won        all levels cleared
//   timeout         level timer expired
//
// state      | meaning
// -----------+----------------------------------------------------
// IDLE  (0)  | waiting for start, all flags low
// LOAD  (1)  | maze_load high until the loader answers maze_ready
// PLAY  (2)  | player enabled, timer running, moves counted
// LEVEL_DONE | (3) level cleared, display frozen for WIN_HOLD seconds
// GAME_DONE  | (4) last level cleared, game_won high until start
// TIMEOUT(5) | timer expired, timeout high until start retries level
module maze_game_controller #(
   parameter int NUM_LEVELS = 4,
   parameter int LVL_W      = 2,
   parameter int CLK_DIV    = 100000000,
   parameter int TIME_LIMIT = 99,
   parameter int WIN_HOLD   = 2,
   parameter int CNT_W      = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   move,
   input  logic                   win,
   input  logic                   game_rst,
   maze_game_controller_if.master maze_bus,
   output logic                   player_en,
   output logic [CNT_W-1:0]       move_count,
   output logic [6:0]             time_left,
   output logic [2:0]             state,
   output logic                   game_won,
   output logic                   timeout
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD       = 3'd1,
      S_PLAY       = 3'd2,
      S_LEVEL_DONE = 3'd3,
      S_GAME_DONE  = 3'd4,
      S_TIMEOUT    = 3'd5
   } state_e;

   localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HOLD_W = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
   localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(CLK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(WIN_HOLD - 1);
   localparam logic [6:0]        TL_INIT   = 7'(TIME_LIMIT);
   localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(NUM_LEVELS - 1);

   state_e            state_q;
   logic [LVL_W-1:0]  level_q;
   logic              maze_load_q;
   logic [PRE_W-1:0]  presc_q;
   logic [HOLD_W-1:0] hold_q;
   logic              presc_wrap;

   assign presc_wrap = (presc_q == PRE_MAX);
   assign state      = state_q;
   assign maze_bus.level = level_q;
   // Reset gates the request combinationally so the loader sees it drop at
   // once, without waiting for the next edge.
   assign maze_bus.maze_load = maze_load_q & rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         level_q     <= '0;
         maze_load_q <= 1'b0;
         player_en   <= 1'b0;
         move_count  <= '0;
         time_left   <= TL_INIT;
         game_won    <= 1'b0;
         timeout     <= 1'b0;
         presc_q     <= '0;
         hold_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q     <= S_LOAD;
                  maze_load_q <= 1'b1;
               end
            end
            S_LOAD: begin
               if (maze_bus.maze_ready) begin
                  state_q     <= S_PLAY;
                  maze_load_q <= 1'b0;
                  player_en   <= 1'b1;
                  move_count  <= '0;
                  time_left   <= TL_INIT;
                  presc_q     <= '0;
               end
            end
            S_PLAY: begin
               // Clear beats a coincident move; a move alongside win still counts.
               if (game_rst)
                  move_count <= '0;
               else if (move && (move_count != '1))
                  move_count <= move_count + 1'b1;

               // Win outranks a timer expiry falling on the same cycle.
               if (win) begin
                  state_q   <= S_LEVEL_DONE;
                  player_en <= 1'b0;
                  presc_q   <= '0;
                  hold_q    <= HOLD_INIT;
               end else if (presc_wrap) begin
                  presc_q   <= '0;
                  time_left <= time_left - 1'b1;
                  if (time_left == 7'd1) begin
                     state_q   <= S_TIMEOUT;
                     player_en <= 1'b0;
                     timeout   <= 1'b1;
                  end
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
            end
            S_LEVEL_DONE: begin
               if (presc_wrap) begin
                  presc_q <= '0;
                  if (hold_q == '0) begin
                     if (level_q == LVL_LAST) begin
                        state_q  <= S_GAME_DONE;
                        game_won <= 1'b1;
                     end else begin
                        level_q     <= level_q + 1'b1;
                        state_q     <= S_LOAD;
                        maze_load_q <= 1'b1;
                     end
                  end else begin
                     hold_q <= hold_q - 1'b1;
                  end
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
            end
            S_GAME_DONE: begin
               if (start) begin
                  level_q     <= '0;
                  game_won    <= 1'b0;
                  state_q     <= S_LOAD;
                  maze_load_q <= 1'b1;
               end
            end
            S_TIMEOUT: begin
               if (start) begin
                  timeout     <= 1'b0;
                  state_q     <= S_LOAD;
                  maze_load_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               maze_load_q <= 1'b0;
               player_en   <= 1'b0;
               game_won    <= 1'b0;
               timeout     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maze_game_controller.sv
module tb_maze_game_controller;

   localparam int NUM_LEVELS = 2;
   localparam int LVL_W      = 2;
   localparam int CLK_DIV    = 4;
   localparam int TIME_LIMIT = 3;
   localparam int WIN_HOLD   = 1;
   localparam int CNT_W      = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, move, win, game_rst;
   logic             player_en, game_won, timeout;
   logic [CNT_W-1:0] move_count;
   logic [6:0]       time_left;
   logic [2:0]       state;

   int checks   = 0;
   int failures = 0;

   maze_game_controller_if #(.LVL_W(LVL_W)) bus ();

   maze_game_controller #(
      .NUM_LEVELS(NUM_LEVELS), .LVL_W(LVL_W), .CLK_DIV(CLK_DIV),
      .TIME_LIMIT(TIME_LIMIT), .WIN_HOLD(WIN_HOLD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .move(move), .win(win),
      .game_rst(game_rst), .maze_bus(bus), .player_en(player_en),
      .move_count(move_count), .time_left(time_left), .state(state),
      .game_won(game_won), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       st, mv, wn, gr, mr;
      logic [2:0] s;
      logic       ml, pe;
      logic [1:0] mc;
      logic [6:0] tl;
      logic [1:0] lv;
      logic       gw, to;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic st, mv, wn, gr, mr,
                              input logic [2:0] s, input logic ml, pe,
                              input logic [1:0] mc, input logic [6:0] tl,
                              input logic [1:0] lv, input logic gw, to);
      vec_t r;
      r.st = st; r.mv = mv; r.wn = wn; r.gr = gr; r.mr = mr;
      r.s = s; r.ml = ml; r.pe = pe; r.mc = mc; r.tl = tl;
      r.lv = lv; r.gw = gw; r.to = to;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic st, mv, wn, gr, mr);
      start = st; move = mv; win = wn; game_rst = gr; bus.maze_ready = mr;
   endtask

   function automatic logic [31:0] pack_out();
      return {14'd0, state, bus.maze_load, player_en, move_count, time_left,
              bus.level, game_won, timeout};
   endfunction

   function automatic logic [31:0] pack_exp(input vec_t e);
      return {14'd0, e.s, e.ml, e.pe, e.mc, e.tl, e.lv, e.gw, e.to};
   endfunction

   initial begin
      // inputs: st mv wn gr mr | expected: state ml pe mc tl lv gw to
      vecs.push_back(v(1,0,0,0,0, 1,1,0,0,3,0,0,0));   // start -> LOAD
      repeat (4) vecs.push_back(v(0,0,0,0,0, 1,1,0,0,3,0,0,0));
      vecs.push_back(v(0,0,0,0,1, 2,0,1,0,3,0,0,0));   // maze_ready -> PLAY
      vecs.push_back(v(0,1,0,0,0, 2,0,1,1,3,0,0,0));
      vecs.push_back(v(0,1,0,0,0, 2,0,1,2,3,0,0,0));
      vecs.push_back(v(0,1,0,0,0, 2,0,1,3,3,0,0,0));
      vecs.push_back(v(0,1,0,0,0, 2,0,1,3,2,0,0,0));   // saturate, 1st second
      vecs.push_back(v(0,1,0,1,0, 2,0,1,0,2,0,0,0));   // game_rst beats move
      vecs.push_back(v(0,0,0,0,0, 2,0,1,0,2,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 2,0,1,0,2,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 2,0,1,0,1,0,0,0));
      repeat (3) vecs.push_back(v(0,0,0,0,0, 2,0,1,0,1,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 5,0,0,0,0,0,0,1));   // TIMEOUT
      vecs.push_back(v(0,1,1,1,1, 5,0,0,0,0,0,0,1));   // ignored outside PLAY
      vecs.push_back(v(1,0,0,0,0, 1,1,0,0,0,0,0,0));   // retry same level
      vecs.push_back(v(0,0,0,0,1, 2,0,1,0,3,0,0,0));
      vecs.push_back(v(0,1,0,0,0, 2,0,1,1,3,0,0,0));
      vecs.push_back(v(0,0,0,0,1, 2,0,1,1,3,0,0,0));   // stray maze_ready
      vecs.push_back(v(0,0,0,0,0, 2,0,1,1,3,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 2,0,1,1,2,0,0,0));
      repeat (3) vecs.push_back(v(0,0,0,0,0, 2,0,1,1,2,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 2,0,1,1,1,0,0,0));
      repeat (3) vecs.push_back(v(0,0,0,0,0, 2,0,1,1,1,0,0,0));
      vecs.push_back(v(0,1,1,0,0, 3,0,0,2,1,0,0,0));   // win beats expiry
      vecs.push_back(v(0,1,0,1,0, 3,0,0,2,1,0,0,0));
      vecs.push_back(v(1,0,0,0,0, 3,0,0,2,1,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 3,0,0,2,1,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 1,1,0,2,1,1,0,0));   // advance to level 1
      vecs.push_back(v(0,0,0,0,1, 2,0,1,0,3,1,0,0));
      vecs.push_back(v(0,0,1,0,0, 3,0,0,0,3,1,0,0));
      repeat (3) vecs.push_back(v(0,0,0,0,0, 3,0,0,0,3,1,0,0));
      vecs.push_back(v(0,0,0,0,0, 4,0,0,0,3,1,1,0));   // GAME_DONE
      vecs.push_back(v(0,0,0,0,0, 4,0,0,0,3,1,1,0));
      vecs.push_back(v(1,0,0,0,0, 1,1,0,0,3,0,0,0));   // restart at level 0

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'(state), 32'd0);
      check("reset_flags", {28'd0, bus.maze_load, player_en, game_won, timeout}, 32'd0);
      check("reset_level", 32'(bus.level), 32'd0);
      check("reset_move_count", 32'(move_count), 32'd0);
      check("reset_time_left", 32'(time_left), 32'd3);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].st, vecs[i].mv, vecs[i].wn, vecs[i].gr, vecs[i].mr);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
      end

      // Reset in the middle of the load handshake.
      drive(0, 0, 0, 0, 0);
      check("load_before_rst", 32'(bus.maze_load), 32'd1);
      rst_n = 1'b0;
      #1;
      check("load_drop_immediate", 32'(bus.maze_load), 32'd0);
      @(posedge clk);
      #1;
      check("rst_load_state", 32'(state), 32'd0);
      check("rst_load_outs", {23'd0, bus.maze_load, bus.level, time_left},
            {23'd0, 1'b0, 2'd0, 7'd3});
      rst_n = 1'b1;
      drive(1, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("restart_after_rst", {28'd0, state, bus.maze_load}, {28'd0, 3'd1, 1'b1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
